// File: rtl/lbm_pkg.sv
// Shared D2Q9 lattice constants, fixed-point type and the moment-sweep state encoding.
package lbm_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_Q      = 9;

    typedef logic signed [31:0] fix_t;
    localparam fix_t FIX_ONE = 32'h01_000000;

    localparam int EX [NUM_Q] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
    localparam int EY [NUM_Q] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} mc_state_e;

    // Unused population slots (q >= NUM_Q) contribute no momentum.
    function automatic int dir_x(input logic [3:0] q);
        return (q < 4'(NUM_Q)) ? EX[q] : 0;
    endfunction

    function automatic int dir_y(input logic [3:0] q);
        return (q < 4'(NUM_Q)) ? EY[q] : 0;
    endfunction

endpackage

// File: rtl/d2q9_accum.sv
// Density/momentum accumulator for one lattice cell; add/subtract only, wraps on overflow.
module d2q9_accum
    import lbm_pkg::*;
#(
    parameter int Q_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic [Q_WIDTH-1:0]    q_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] rho_o,
    output logic [DATA_WIDTH-1:0] jx_o,
    output logic [DATA_WIDTH-1:0] jy_o
);

    fix_t rho_q, rho_d;
    fix_t jx_q, jx_d;
    fix_t jy_q, jy_d;
    int   dx, dy;

    always_comb begin
        dx    = dir_x(4'(q_i));
        dy    = dir_y(4'(q_i));
        rho_d = rho_q;
        jx_d  = jx_q;
        jy_d  = jy_q;
        if (clear_i) begin
            rho_d = '0;
            jx_d  = '0;
            jy_d  = '0;
        end else if (enable_i) begin
            rho_d = rho_q + data_i;
            if (dx > 0)      jx_d = jx_q + data_i;
            else if (dx < 0) jx_d = jx_q - data_i;
            if (dy > 0)      jy_d = jy_q + data_i;
            else if (dy < 0) jy_d = jy_q - data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rho_q <= '0;
            jx_q  <= '0;
            jy_q  <= '0;
        end else begin
            rho_q <= rho_d;
            jx_q  <= jx_d;
            jy_q  <= jy_d;
        end
    end

    // Next-state sums are exported so the caller can latch the total on the last accumulate edge.
    assign rho_o = rho_d;
    assign jx_o  = jx_d;
    assign jy_o  = jy_d;

endmodule

// File: rtl/moment_calc.sv
// Sweeps all lattice cells, reads f0..f8 and writes rho/jx/jy into the moment RAMs.
module moment_calc
    import lbm_pkg::*;
#(
    parameter int DEPTH         = 256,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int Q_WIDTH       = 4
) (
    input  logic                             Clk,
    input  logic                             Reset_n,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic [ADDRESS_WIDTH+Q_WIDTH-1:0] dist_address,
    output logic                             dist_re,
    input  logic [DATA_WIDTH-1:0]            dist_data,
    output logic [ADDRESS_WIDTH-1:0]         address,
    output logic                             WE,
    output logic [DATA_WIDTH-1:0]            rho_data_in,
    output logic [DATA_WIDTH-1:0]            jx_data_in,
    output logic [DATA_WIDTH-1:0]            jy_data_in
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_CELL = ADDRESS_WIDTH'(DEPTH - 1);
    localparam logic [Q_WIDTH-1:0]       LAST_Q    = Q_WIDTH'(NUM_Q - 1);

    mc_state_e                  state_q;
    logic [ADDRESS_WIDTH-1:0]   cell_q, cell_inc;
    logic [Q_WIDTH-1:0]         q_q, q_inc;
    logic                       rd_valid_q;
    logic [Q_WIDTH-1:0]         rd_q_q;
    logic                       acc_clear;
    logic [DATA_WIDTH-1:0]      acc_rho, acc_jx, acc_jy;

    assign cell_inc  = cell_q + ADDRESS_WIDTH'(1);
    assign q_inc     = q_q + Q_WIDTH'(1);
    assign acc_clear = (state_q == IDLE) || (state_q == WRITE);

    d2q9_accum #(
        .Q_WIDTH(Q_WIDTH)
    ) u_accum (
        .clk_i   (Clk),
        .rst_ni  (Reset_n),
        .clear_i (acc_clear),
        .enable_i(rd_valid_q),
        .q_i     (rd_q_q),
        .data_i  (dist_data),
        .rho_o   (acc_rho),
        .jx_o    (acc_jx),
        .jy_o    (acc_jy)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            cell_q       <= '0;
            q_q          <= '0;
            rd_valid_q   <= 1'b0;
            rd_q_q       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            dist_re      <= 1'b0;
            dist_address <= '0;
            address      <= '0;
            WE           <= 1'b0;
            rho_data_in  <= '0;
            jx_data_in   <= '0;
            jy_data_in   <= '0;
        end else begin
            WE         <= 1'b0;
            done       <= 1'b0;
            // RAM returns data one cycle after the address; track which q it belongs to.
            rd_valid_q <= dist_re;
            rd_q_q     <= dist_address[Q_WIDTH-1:0];
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= READ;
                        cell_q       <= '0;
                        q_q          <= '0;
                        busy         <= 1'b1;
                        dist_re      <= 1'b1;
                        dist_address <= '0;
                        address      <= '0;
                    end
                end
                READ: begin
                    if (q_q == LAST_Q) begin
                        state_q <= DRAIN;
                        dist_re <= 1'b0;
                    end else begin
                        q_q          <= q_inc;
                        dist_address <= {cell_q, q_inc};
                    end
                end
                DRAIN: begin
                    state_q     <= WRITE;
                    WE          <= 1'b1;
                    rho_data_in <= acc_rho;
                    jx_data_in  <= acc_jx;
                    jy_data_in  <= acc_jy;
                end
                WRITE: begin
                    if (cell_q == LAST_CELL) begin
                        state_q <= DONE;
                        done    <= 1'b1;
                    end else begin
                        state_q      <= READ;
                        cell_q       <= cell_inc;
                        address      <= cell_inc;
                        q_q          <= '0;
                        dist_re      <= 1'b1;
                        dist_address <= {cell_inc, {Q_WIDTH{1'b0}}};
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    cell_q  <= '0;
                    address <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_moment_calc.sv
// Scoreboard bench for moment_calc: directed distribution fields with hand-computed moments.
module tb_moment_calc;

    localparam int DEPTH     = 256;
    localparam int AW        = 8;
    localparam int QW        = 4;
    localparam int DW        = 32;
    localparam int SWEEP_CYC = DEPTH * 11;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          start;
    logic          busy, done, dist_re, WE;
    logic [AW+QW-1:0] dist_address;
    logic [DW-1:0] dist_data = '0;
    logic [AW-1:0] address;
    logic [DW-1:0] rho_data_in, jx_data_in, jy_data_in;

    logic [DW-1:0] mem [DEPTH*16];

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] r;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0, errors = 0;
    int we_cnt = 0, done_cnt = 0, done_cyc = 0, cyc = 0;

    moment_calc #(
        .DEPTH        (DEPTH),
        .ADDRESS_WIDTH(AW),
        .Q_WIDTH      (QW)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .dist_address(dist_address),
        .dist_re     (dist_re),
        .dist_data   (dist_data),
        .address     (address),
        .WE          (WE),
        .rho_data_in (rho_data_in),
        .jx_data_in  (jx_data_in),
        .jy_data_in  (jy_data_in)
    );

    always #10 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;
    always @(posedge Clk) if (dist_re) dist_data <= mem[dist_address];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per write strobe.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Reset_n === 1'b1) begin
                if (WE === 1'b1) begin
                    we_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write actual_addr=%0d required=no write", address);
                    end else begin
                        e = exp_q.pop_front();
                        chk("address", {24'd0, address}, {24'd0, e.a});
                        chk("rho", rho_data_in, e.r);
                        chk("jx", jx_data_in, e.x);
                        chk("jy", jy_data_in, e.y);
                    end
                end
                if (done === 1'b1) begin
                    done_cnt++;
                    done_cyc = cyc;
                    chk("busy_at_done", {31'd0, busy}, 1);
                end
            end
        end
    end

    // Slots q=9..15 hold junk so any stray read corrupts the sums.
    task automatic fill(input logic [DW-1:0] v);
        for (int i = 0; i < DEPTH * 16; i++) mem[i] = ((i % 16) < 9) ? v : 32'hDEAD_BEEF;
    endtask

    task automatic push1(input int c, input logic [DW-1:0] r, input logic [DW-1:0] x,
                         input logic [DW-1:0] y);
        exp_q.push_back({AW'(c), r, x, y});
    endtask

    task automatic push_all(input logic [DW-1:0] r, input logic [DW-1:0] x, input logic [DW-1:0] y);
        for (int c = 0; c < DEPTH; c++) push1(c, r, x, y);
    endtask

    task automatic do_start(output int k);
        we_cnt   = 0;
        done_cnt = 0;
        @(posedge Clk);
        #1 start = 1'b1;
        @(posedge Clk);
        #1 k = cyc;
        start = 1'b0;
    endtask

    task automatic pulse_at(input int c);
        while (cyc < c) begin
            @(posedge Clk);
            #1;
        end
        start = 1'b1;
        @(posedge Clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int k);
        int n = 0;
        while (done_cnt == 0 && n < SWEEP_CYC + 50) begin
            @(posedge Clk);
            n++;
        end
        if (done_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no done required=done after %0d cycles", SWEEP_CYC);
        end else begin
            chk("done_latency", done_cyc - k, SWEEP_CYC);
            @(negedge Clk);
            chk("busy_after_done", {31'd0, busy}, 0);
        end
    endtask

    task automatic sweep_end_checks();
        repeat (20) @(posedge Clk);
        #1;
        chk("we_count", we_cnt, DEPTH);
        chk("done_count", done_cnt, 1);
        chk("queue_empty", exp_q.size(), 0);
        chk("idle_busy", {31'd0, busy}, 0);
    endtask

    initial begin
        int k;
        Reset_n = 1'b0;
        start   = 1'b0;
        fill('0);
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_we", {31'd0, WE}, 0);
        chk("rst_re", {31'd0, dist_re}, 0);
        chk("rst_addr", {24'd0, address}, 0);
        chk("rst_dist_addr", {20'd0, dist_address}, 0);
        chk("rst_rho", rho_data_in, 0);
        chk("rst_jx", jx_data_in, 0);
        chk("rst_jy", jy_data_in, 0);
        Reset_n = 1'b1;
        repeat (100) @(posedge Clk);
        #1;
        chk("idle_we_count", we_cnt, 0);
        chk("idle_busy", {31'd0, busy}, 0);

        // Uniform field
        fill(32'h0020_0000);
        push_all(32'h0120_0000, 32'h0, 32'h0);
        do_start(k);
        wait_done(k);
        sweep_end_checks();

        // Directional
        fill('0);
        mem[5*16+1] = lbm_pkg::FIX_ONE;
        mem[6*16+7] = 32'h0080_0000;
        for (int c = 0; c < DEPTH; c++) begin
            if (c == 5)      push1(c, 32'h0100_0000, 32'h0100_0000, 32'h0);
            else if (c == 6) push1(c, 32'h0080_0000, 32'hFF80_0000, 32'hFF80_0000);
            else             push1(c, 32'h0, 32'h0, 32'h0);
        end
        do_start(k);
        wait_done(k);
        sweep_end_checks();

        // Start while busy, including the DONE cycle
        fill(32'h0020_0000);
        push_all(32'h0120_0000, 32'h0, 32'h0);
        do_start(k);
        fork
            pulse_at(k + 10);
            pulse_at(k + 1000);
            pulse_at(k + SWEEP_CYC);
            wait_done(k);
        join
        sweep_end_checks();

        // Reset mid-sweep, landing on cell 45's write cycle
        push_all(32'h0120_0000, 32'h0, 32'h0);
        do_start(k);
        while (cyc < k + 505) begin
            @(posedge Clk);
            #1;
        end
        chk("we_before_reset", {31'd0, WE}, 1);
        #1 Reset_n = 1'b0;
        #1;
        chk("async_we", {31'd0, WE}, 0);
        chk("async_busy", {31'd0, busy}, 0);
        chk("async_re", {31'd0, dist_re}, 0);
        chk("async_addr", {24'd0, address}, 0);
        chk("async_rho", rho_data_in, 0);
        chk("partial_writes", we_cnt, 45);
        exp_q.delete();
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        push_all(32'h0120_0000, 32'h0, 32'h0);
        do_start(k);
        wait_done(k);
        sweep_end_checks();

        // Wrapping sum
        fill(32'h7F00_0000);
        push_all(32'h7700_0000, 32'h0, 32'h0);
        do_start(k);
        wait_done(k);
        sweep_end_checks();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
